// File: rtl/riscv_store_check.sv
// riscv_store_check
// Store-side DIFT tag check. Every store accepted from EX is checked against the
// Tag Check Register. Three checks apply:
//   - the rs2 data tag against the S policy bit;
//   - the rs1 address tag against the SA policy bit;
//   - optionally (D), the tag already held by the destination word, read from tag memory.
// A violation raises exception_o, which stays high until exc_ack_i. A clean store
// writes the data tag into tag memory and then pulses commit_o for one cycle.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   store_req_i/gnt_o   store handshake from EX (gnt_o == ready, high only in IDLE)
//   store_addr_i        store byte address (word index taken from [TAG_ADDR_WIDTH+1:2])
//   store_data_tag_i    rs2 tag
//   store_addr_tag_i    rs1 tag
//   tcr_i               Tag Check Register
//   tagmem_*            tag memory port (req/gnt, we, addr, wdata, rvalid/rdata)
//   commit_o            one-cycle pulse: store may complete to data memory
//   exception_o         tag violation, held until exc_ack_i
//   busy_o              FSM not idle
//   state_dbg_o         current FSM state encoding
//
// Handshake: a transfer happens on a rising clk edge where valid (req) and
// ready (gnt) are both high. While req is high and gnt is low, the requester
// holds req and all payload signals (address, we, wdata) stable.
module riscv_store_check #(
  parameter int TAG_ADDR_WIDTH    = 16,
  parameter int LOADSTORE_CHECK_S  = 2,
  parameter int LOADSTORE_CHECK_SA = 1,
  parameter int LOADSTORE_CHECK_D  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      store_req_i,
  output logic                      store_gnt_o,
  input  logic [31:0]               store_addr_i,
  input  logic                      store_data_tag_i,
  input  logic                      store_addr_tag_i,
  input  logic [31:0]               tcr_i,
  output logic                      tagmem_req_o,
  input  logic                      tagmem_gnt_i,
  output logic                      tagmem_we_o,
  output logic [TAG_ADDR_WIDTH-1:0] tagmem_addr_o,
  output logic                      tagmem_wdata_o,
  input  logic                      tagmem_rvalid_i,
  input  logic                      tagmem_rdata_i,
  output logic                      commit_o,
  output logic                      exception_o,
  input  logic                      exc_ack_i,
  output logic                      busy_o,
  output logic [2:0]                state_dbg_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4,
    EXC     = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [TAG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      data_tag_q, data_tag_d;

  logic chk_s, chk_sa, chk_d, src_violation;

  // Remaining address/TCR bits carry no meaning for this block.
  logic unused_bits;
  assign unused_bits = ^{store_addr_i, tcr_i};

  // The whole source-side decision (S/SA) and the D choice are taken in the
  // accept cycle, so later tcr_i changes cannot affect an in-flight store.
  // Only the word index and data tag are needed after acceptance.
  assign chk_s         = tcr_i[LOADSTORE_CHECK_S];
  assign chk_sa        = tcr_i[LOADSTORE_CHECK_SA];
  assign chk_d         = tcr_i[LOADSTORE_CHECK_D];
  assign src_violation = (store_data_tag_i & chk_s) | (store_addr_tag_i & chk_sa);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_tag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_tag_q <= data_tag_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_tag_d = data_tag_q;
    unique case (state_q)
      IDLE: begin
        if (store_req_i) begin
          addr_d     = store_addr_i[TAG_ADDR_WIDTH+1:2];
          data_tag_d = store_data_tag_i;
          if (src_violation)  state_d = EXC;
          else if (chk_d)     state_d = RD_REQ;
          else                state_d = WR_REQ;
        end
      end
      RD_REQ:  if (tagmem_gnt_i) state_d = RD_WAIT;
      RD_WAIT: begin
        // A set destination tag means the word is already tainted.
        if (tagmem_rvalid_i) state_d = tagmem_rdata_i ? EXC : WR_REQ;
      end
      WR_REQ:  if (tagmem_gnt_i) state_d = DONE;
      DONE:    state_d = IDLE;
      EXC:     if (exc_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic (Moore: depends on state and latched fields only)
  always_comb begin
    store_gnt_o    = 1'b0;
    tagmem_req_o   = 1'b0;
    tagmem_we_o    = 1'b0;
    tagmem_wdata_o = 1'b0;
    commit_o       = 1'b0;
    exception_o    = 1'b0;
    busy_o         = 1'b1;
    tagmem_addr_o  = addr_q;
    state_dbg_o    = state_q;
    unique case (state_q)
      IDLE: begin
        store_gnt_o = 1'b1;
        busy_o      = 1'b0;
      end
      RD_REQ:  tagmem_req_o = 1'b1;
      RD_WAIT: ;
      WR_REQ: begin
        tagmem_req_o   = 1'b1;
        tagmem_we_o    = 1'b1;
        tagmem_wdata_o = data_tag_q;
      end
      DONE:    commit_o    = 1'b1;
      EXC:     exception_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/riscv_store_check.md
Name: riscv_store_check

Overview:
- Store-side counterpart of the DIFT load tag check in RI5CY.
- For every store issued by EX, checks the rs1 (address) tag, the rs2 (data) tag and the tag already held at the destination memory word against the Tag Check Register (TCR).
- On a violation, raises a held exception. Otherwise, writes the propagated tag into tag memory and releases the store.
- Sits between the EX stage / LSU and the tag memory port; the controller consumes exception_o.

Parameters:
- TAG_ADDR_WIDTH, 16, word index width into tag memory (one tag bit per 32-bit word).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- store_req_i  input  1  store valid from EX
- store_gnt_o  output  1  store accepted (ready)
- store_addr_i  input  32  store byte address
- store_data_tag_i  input  1  rs2 (source data) tag
- store_addr_tag_i  input  1  rs1 (source address) tag
- tcr_i  input  32  Tag Check Register; bits LOADSTORE_CHECK_S/_SA/_D from riscv_defines
- tagmem_req_o  output  1  tag memory request
- tagmem_gnt_i  input  1  tag memory grant
- tagmem_we_o  output  1  1 = write, 0 = read
- tagmem_addr_o  output  TAG_ADDR_WIDTH  word index, store_addr[TAG_ADDR_WIDTH+1:2]
- tagmem_wdata_o  output  1  tag to write
- tagmem_rvalid_i  input  1  read data valid
- tagmem_rdata_i  input  1  destination word tag
- commit_o  output  1  one-cycle pulse: store may complete to data memory
- exception_o  output  1  tag violation, held until acknowledged
- exc_ack_i  input  1  controller acknowledge
- busy_o  output  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - state = IDLE.
  - All outputs 0 except store_gnt_o = 1 (IDLE).
  - Latched fields cleared.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE, EXC.
- store_gnt_o = (state == IDLE). A store is accepted when store_req_i && store_gnt_o.
- On accept, latch: the address index, both tags, and tcr_i check bits S, SA, D. Later tcr_i changes do not affect an in-flight store.
- Transitions out of IDLE on accept:
  - If (data_tag & S) or (addr_tag & SA): go to EXC. No tag memory traffic.
  - Else if D = 1: go to RD_REQ.
  - Else: go to WR_REQ (read skipped).
- RD_REQ:
  - Drive tagmem_req_o = 1, tagmem_we_o = 0, and the address.
  - Hold until tagmem_gnt_i, then go to RD_WAIT.
- RD_WAIT:
  - Wait for tagmem_rvalid_i.
  - If tagmem_rdata_i = 1 (D already known set): go to EXC. Else go to WR_REQ.
- WR_REQ:
  - Drive tagmem_req_o = 1, tagmem_we_o = 1, tagmem_wdata_o = latched data tag.
  - Hold until tagmem_gnt_i, then go to DONE.
- DONE:
  - commit_o = 1 for exactly this one cycle, then go to IDLE.
- EXC:
  - exception_o = 1. No commit, no tag write.
  - When exc_ack_i is sampled high in EXC, go to IDLE; exception_o is low in the following cycle.
- Minimum latency, no violation, D = 1, zero-wait memory (gnt same cycle, rvalid next cycle):
  - accept at cycle 0;
  - read req/gnt at cycle 1;
  - rvalid at cycle 2;
  - write req/gnt at cycle 3;
  - commit_o at cycle 4.
  - With D = 0: commit_o at cycle 2.
- Boundary conditions:
  - tagmem_rvalid_i outside RD_WAIT is ignored. rvalid in the same cycle as the read grant is not supported; the memory returns rvalid at least one cycle after the grant.
  - exc_ack_i outside EXC is ignored.
  - store_req_i while busy is not accepted; EX holds it.
  - Request/address/we/wdata stay stable while a request is ungranted.
  - rst mid-operation returns to IDLE the next cycle. A pending read is abandoned; its late rvalid is ignored. A pending exception is dropped.
  - Address bits [1:0] and bits above TAG_ADDR_WIDTH+1 are ignored.

Test Plan:
- Clean store, D = 1: addr 0x0000_0104, data_tag = 1, S = SA = 0, rdata = 0, zero-wait memory -> read then write at index 0x41 with wdata = 1, commit_o pulse at cycle 4, exception_o = 0.
- Source violation: data_tag = 1, S = 1 -> EXC the cycle after accept, no tagmem_req_o ever; exception_o holds until exc_ack_i, low the next cycle.
- Destination violation: D = 1, rdata = 1 -> exception_o high, no write request, no commit_o.
- D = 0, addr_tag = 1, SA = 0: gnt delayed 3 cycles -> no read, write held stable 3 cycles, commit_o one cycle after gnt.
- Change tcr_i after accept (set S) -> decision uses the latched value, the store commits.
- Assert rst while in RD_WAIT, then rvalid = 1 next cycle -> IDLE, store_gnt_o = 1, no commit, no exception; a following store completes normally.
